// File: rtl/mm_port_arbiter.sv
// mm_port_arbiter: round-robin arbiter sharing the byte-wide main-memory port of the
// memory-map manager between NREQ requesters. Only one transaction is in flight at a time.
//
// Ports:
//   mem_clk, rst          clock (rising edge) and asynchronous active-high reset
//   req/we/addr/wdata     per-requester level request, direction, flattened address and byte
//   gnt, ack              one-hot owner (accept..ack) and one-cycle completion pulse
//   rdata, busy           last read byte (held), transaction-in-flight flag
//   mm_raddr/mm_waddr     address to the manager (both carry the latched address)
//   mm_wdata/mm_wren      write byte and single-cycle write strobe to the manager
//   mm_rdata              read byte from the manager, valid RD_LAT cycles after raddr
module mm_port_arbiter #(
  parameter int unsigned NREQ   = 2,
  parameter int unsigned AW     = 32,
  parameter int unsigned RD_LAT = 2
) (
  input  logic              mem_clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ-1:0]   we,
  input  logic [NREQ*AW-1:0] addr,
  input  logic [NREQ*8-1:0] wdata,
  output logic [NREQ-1:0]   gnt,
  output logic [NREQ-1:0]   ack,
  output logic [7:0]        rdata,
  output logic              busy,
  output logic [AW-1:0]     mm_raddr,
  output logic [AW-1:0]     mm_waddr,
  output logic [7:0]        mm_wdata,
  output logic              mm_wren,
  input  logic [7:0]        mm_rdata
);

  localparam int unsigned LW = (NREQ > 2) ? 2 : 1;

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StAck} state_e;

  state_e            state_q, state_d;
  logic [LW-1:0]     last_q, last_d;
  logic              we_q, we_d;
  logic [2:0]        cnt_q, cnt_d;
  logic [NREQ-1:0]   gnt_q, gnt_d;
  logic [NREQ-1:0]   ack_q, ack_d;
  logic [7:0]        rdata_q, rdata_d;
  logic              busy_q, busy_d;
  logic [AW-1:0]     raddr_q, raddr_d;
  logic [AW-1:0]     waddr_q, waddr_d;
  logic [7:0]        wdata_q, wdata_d;
  logic              wren_q, wren_d;

  logic              found;
  logic [LW-1:0]     pick;
  logic [LW-1:0]     cand;

  always_comb begin
    // Round-robin search starting just after the last winner.
    found = 1'b0;
    pick  = '0;
    cand  = '0;
    for (int i = 1; i <= int'(NREQ); i++) begin
      cand = LW'((int'(last_q) + i) % int'(NREQ));
      if (!found && req[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    we_d    = we_q;
    cnt_d   = cnt_q;
    gnt_d   = gnt_q;
    ack_d   = '0;
    rdata_d = rdata_q;
    busy_d  = busy_q;
    raddr_d = raddr_q;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    wren_d  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (found) begin
          last_d  = pick;
          we_d    = we[pick];
          gnt_d   = NREQ'(1) << pick;
          busy_d  = 1'b1;
          raddr_d = addr[int'(pick)*int'(AW) +: AW];
          waddr_d = addr[int'(pick)*int'(AW) +: AW];
          wdata_d = wdata[int'(pick)*8 +: 8];
          // Strobe is registered, so it is visible exactly in the ISSUE cycle.
          wren_d  = we[pick];
          state_d = StIssue;
        end
      end
      StIssue: begin
        if (we_q) begin
          ack_d   = gnt_q;
          state_d = StAck;
        end else begin
          cnt_d   = 3'(RD_LAT);
          state_d = StWait;
        end
      end
      StWait: begin
        cnt_d = cnt_q - 3'd1;
        if (cnt_q == 3'd1) begin
          rdata_d = mm_rdata;
          ack_d   = gnt_q;
          state_d = StAck;
        end
      end
      StAck: begin
        gnt_d   = '0;
        busy_d  = 1'b0;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge mem_clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      last_q  <= LW'(NREQ - 1);
      we_q    <= 1'b0;
      cnt_q   <= '0;
      gnt_q   <= '0;
      ack_q   <= '0;
      rdata_q <= '0;
      busy_q  <= 1'b0;
      raddr_q <= '0;
      waddr_q <= '0;
      wdata_q <= '0;
      wren_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      we_q    <= we_d;
      cnt_q   <= cnt_d;
      gnt_q   <= gnt_d;
      ack_q   <= ack_d;
      rdata_q <= rdata_d;
      busy_q  <= busy_d;
      raddr_q <= raddr_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      wren_q  <= wren_d;
    end
  end

  assign gnt      = gnt_q;
  assign ack      = ack_q;
  assign rdata    = rdata_q;
  assign busy     = busy_q;
  assign mm_raddr = raddr_q;
  assign mm_waddr = waddr_q;
  assign mm_wdata = wdata_q;
  assign mm_wren  = wren_q;

endmodule

// File: tb/tb_mm_port_arbiter.sv
// Directed bench for mm_port_arbiter (NREQ=2, AW=32, RD_LAT=2). Cycle 0 is the period in
// which a request is first seen; outputs are sampled on the falling edge.
module tb_mm_port_arbiter;

  localparam int unsigned NREQ   = 2;
  localparam int unsigned AW     = 32;
  localparam int unsigned RD_LAT = 2;

  logic             mem_clk = 1'b0;
  logic             rst;
  logic [NREQ-1:0]  req;
  logic [NREQ-1:0]  we;
  logic [NREQ*AW-1:0] addr;
  logic [NREQ*8-1:0] wdata;
  logic [NREQ-1:0]  gnt;
  logic [NREQ-1:0]  ack;
  logic [7:0]       rdata;
  logic             busy;
  logic [AW-1:0]    mm_raddr;
  logic [AW-1:0]    mm_waddr;
  logic [7:0]       mm_wdata;
  logic             mm_wren;
  logic [7:0]       mm_rdata;

  int n_checks = 0;
  int n_errors = 0;
  int wren_cnt = 0;
  int ack_cnt  = 0;
  int gnt_bad  = 0;

  mm_port_arbiter #(
    .NREQ  (NREQ),
    .AW    (AW),
    .RD_LAT(RD_LAT)
  ) u_dut (
    .mem_clk (mem_clk),
    .rst     (rst),
    .req     (req),
    .we      (we),
    .addr    (addr),
    .wdata   (wdata),
    .gnt     (gnt),
    .ack     (ack),
    .rdata   (rdata),
    .busy    (busy),
    .mm_raddr(mm_raddr),
    .mm_waddr(mm_waddr),
    .mm_wdata(mm_wdata),
    .mm_wren (mm_wren),
    .mm_rdata(mm_rdata)
  );

  always #5 mem_clk = ~mem_clk;

  // Memory model: data for raddr appears RD_LAT (=2) cycles later.
  function automatic logic [7:0] mem_f(input logic [AW-1:0] a);
    return a[7:0] ^ 8'h1C;
  endfunction

  logic [7:0] pipe1, pipe2;
  always @(posedge mem_clk) begin
    pipe1 <= mem_f(mm_raddr);
    pipe2 <= pipe1;
  end
  assign mm_rdata = pipe2;

  always @(posedge mem_clk) begin
    if (mm_wren) wren_cnt <= wren_cnt + 1;
    if (ack != '0) ack_cnt <= ack_cnt + 1;
  end

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge mem_clk);
    if (gnt != 2'b00 && gnt != 2'b01 && gnt != 2'b10) gnt_bad++;
  endtask

  task automatic wait_ack(output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (ack != '0) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  initial begin
    bit ok;
    int w0, a0;
    logic [1:0] exp_ack;
    req   = '0;
    we    = '0;
    addr  = '0;
    wdata = '0;
    rst   = 1'b1;
    repeat (2) @(negedge mem_clk);

    // Reset values
    check_val("rst_gnt", gnt, 0);
    check_val("rst_ack", ack, 0);
    check_val("rst_busy", busy, 0);
    check_val("rst_rdata", rdata, 0);
    check_val("rst_wren", mm_wren, 0);
    check_val("rst_raddr", mm_raddr, 0);
    check_val("rst_waddr", mm_waddr, 0);
    check_val("rst_wdata", mm_wdata, 0);
    rst = 1'b0;
    tick();

    // Single write from requester 0
    req = 2'b01; we = 2'b01; addr[31:0] = 32'h0000_1234; wdata[7:0] = 8'hA5;
    tick();
    check_val("wr_c1_wren", mm_wren, 1);
    check_val("wr_c1_waddr", mm_waddr, 32'h1234);
    check_val("wr_c1_wdata", mm_wdata, 8'hA5);
    check_val("wr_c1_gnt", gnt, 2'b01);
    check_val("wr_c1_ack", ack, 0);
    tick();
    check_val("wr_c2_ack", ack, 2'b01);
    check_val("wr_c2_gnt", gnt, 2'b01);
    check_val("wr_c2_wren", mm_wren, 0);
    req = 2'b00;
    tick();
    check_val("wr_c3_ack", ack, 0);
    check_val("wr_c3_gnt", gnt, 0);
    check_val("wr_c3_busy", busy, 0);

    // Single read from requester 1
    w0 = wren_cnt;
    req = 2'b10; we = 2'b00; addr[63:32] = 32'h0000_0040;
    tick();
    check_val("rd_c1_gnt", gnt, 2'b10);
    check_val("rd_c1_raddr", mm_raddr, 32'h40);
    check_val("rd_c1_wren", mm_wren, 0);
    tick();
    check_val("rd_c2_ack", ack, 0);
    tick();
    check_val("rd_c3_ack", ack, 0);
    tick();
    check_val("rd_c4_ack", ack, 2'b10);
    check_val("rd_c4_rdata", rdata, 8'h5C);
    req = 2'b00;
    tick();
    check_val("rd_c5_ack", ack, 0);
    check_val("rd_c5_busy", busy, 0);
    check_val("rd_no_wren", wren_cnt - w0, 0);

    // Contention: both reading continuously, grants alternate 0,1,0,1
    req = 2'b11; we = 2'b00; addr[31:0] = 32'h11; addr[63:32] = 32'h22;
    for (int t = 0; t < 4; t++) begin
      wait_ack(ok);
      check_val("cont_ack_seen", ok, 1);
      exp_ack = (t % 2 == 0) ? 2'b01 : 2'b10;
      check_val("cont_ack", ack, exp_ack);
      check_val("cont_gnt", gnt, exp_ack);
      check_val("cont_rdata", rdata, (t % 2 == 0) ? 8'h0D : 8'h3E);
    end
    req = 2'b00;
    tick();
    check_val("cont_gnt_onehot", gnt_bad, 0);

    // Early drop: one-cycle request still completes, single write only
    w0 = wren_cnt;
    req = 2'b01; we = 2'b01; addr[31:0] = 32'h10; wdata[7:0] = 8'h77;
    tick();
    req = 2'b00;
    addr[31:0] = 32'hDEAD; wdata[7:0] = 8'h00;
    check_val("drop_wren", mm_wren, 1);
    check_val("drop_waddr", mm_waddr, 32'h10);
    check_val("drop_wdata", mm_wdata, 8'h77);
    tick();
    check_val("drop_ack", ack, 2'b01);
    repeat (3) tick();
    check_val("drop_ack_gone", ack, 0);
    check_val("drop_one_write", wren_cnt - w0, 1);

    // Reset during WAIT of a read
    req = 2'b01; we = 2'b00; addr[31:0] = 32'h20;
    tick();
    tick();
    check_val("mrst_busy_pre", busy, 1);
    a0 = ack_cnt;
    #2 rst = 1'b1;
    #1;
    check_val("mrst_gnt", gnt, 0);
    check_val("mrst_busy", busy, 0);
    check_val("mrst_ack", ack, 0);
    check_val("mrst_wren", mm_wren, 0);
    tick();
    tick();
    rst = 1'b0;
    req = 2'b11;
    tick();
    check_val("mrst_no_ack", ack_cnt - a0, 0);
    check_val("mrst_first_gnt", gnt, 2'b01);
    wait_ack(ok);
    check_val("mrst_ack_seen", ok, 1);
    check_val("mrst_ack_0", ack, 2'b01);
    check_val("mrst_rdata", rdata, 8'h3C);
    req = 2'b00;
    tick();

    // Held request: three writes back to back through IDLE
    w0 = wren_cnt;
    req = 2'b01; we = 2'b01; addr[31:0] = 32'h100; wdata[7:0] = 8'h99;
    for (int k = 1; k <= 9; k++) begin
      tick();
      check_val("held_wren", mm_wren, (k % 3 == 1) ? 1 : 0);
      check_val("held_ack", ack, (k % 3 == 2) ? 2'b01 : 2'b00);
      check_val("held_busy", busy, (k % 3 != 0) ? 1 : 0);
    end
    req = 2'b00;
    tick();
    check_val("held_wren_count", wren_cnt - w0, 3);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mm_port_arbiter.md
Name: mm_port_arbiter

Overview:
- Shares the single byte-wide main-memory port of the memory-map manager between up to NREQ requesters: instruction receiver, debug/boot loader, future DMA/gfx copy engine.
- Each requester uses a req/ack handshake.
- Arbitration is round-robin, with one outstanding transaction at a time.
- The block drives the manager's raddr/waddr/wdata/wren and returns read data plus a one-cycle ack to the winning requester.

Parameters:
- NREQ, 2, number of requesters (2..4).
- AW, 32, address width.
- RD_LAT, 2, cycles from raddr presented to mm_rdata valid (range 1..7).

Ports:
- mem_clk  in  1  memory-domain clock; all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- req  in  NREQ  per-requester transaction request; level, held until ack.
- we  in  NREQ  per-requester: 1=write, 0=read; sampled at accept.
- addr  in  NREQ*AW  flattened byte addresses; requester i uses bits [i*AW +: AW].
- wdata  in  NREQ*8  flattened write bytes.
- gnt  out  NREQ  one-hot; current owner, from accept until ack.
- ack  out  NREQ  one-hot, one-cycle pulse; transaction complete.
- rdata  out  8  read byte; valid in the ack cycle, held until the next read completes.
- busy  out  1  high while a transaction is in flight.
- mm_raddr  out  AW  to manager raddr.
- mm_waddr  out  AW  to manager waddr.
- mm_wdata  out  8  to manager wdata.
- mm_wren  out  1  to manager wren.
- mm_rdata  in  8  from manager rdata.

Behaviour:
- All outputs are registered.
- Reset values: gnt=0, ack=0, rdata=0, busy=0, mm_raddr=0, mm_waddr=0, mm_wdata=0, mm_wren=0.
- Reset state is IDLE, with round-robin pointer last=NREQ-1, so requester 0 wins first.

States IDLE, ISSUE, WAIT, ACK:
- IDLE:
  - If any req bit is set, choose the first set bit searching upward from last+1 (modulo NREQ).
  - Latch that requester's addr, we and wdata; set gnt one-hot and busy=1; set last to the winner; go to ISSUE.
  - If no req bit is set, stay in IDLE.
- ISSUE (exactly one cycle):
  - mm_raddr and mm_waddr both equal the latched address.
  - mm_wdata equals the latched byte.
  - mm_wren=1 only for a write.
  - A write goes to ACK; a read loads cnt=RD_LAT and goes to WAIT.
- WAIT:
  - mm_wren=0; the address is held; cnt decrements each cycle.
  - When cnt==1, capture mm_rdata into rdata and go to ACK.
- ACK (one cycle):
  - ack[winner]=1.
  - gnt and busy are cleared on exit; return to IDLE.

Timing and handshake rules:
- Latency with accept edge = cycle 0:
  - Write: mm_wren high in cycle 1; ack in cycle 2.
  - Read: rdata valid and ack in cycle 2+RD_LAT.
- Throughput is one transaction per 3 cycles (write) or 3+RD_LAT cycles (read). There is no back-to-back issue without passing through IDLE.
- mm_wren is high only in ISSUE of a write, and never for more than one cycle per transaction.
- Inputs from a requester are ignored after accept; changing addr/wdata mid-transaction has no effect.

Boundary conditions:
- req dropped before ack: the transaction still completes and ack still pulses. A requester must not re-request for the same access.
- req held high after ack: the requester is treated as a new request in the next IDLE and competes under round-robin.
- Simultaneous requests: exactly one grant. With all NREQ requesting continuously, grants rotate 0,1,..,NREQ-1,0.
- Only one requester active: it wins every arbitration, with no idle gaps beyond the IDLE cycle.
- Reset asserted mid-transaction:
  - All outputs clear immediately (asynchronously), including mm_wren.
  - No ack is issued; the pointer returns to NREQ-1.
  - After release, arbitration restarts in IDLE.
- Address is passed through unchanged at full AW; no range checking (the manager decodes I/O windows).

Test Plan:
- Single write: req[0]=1, we=1, addr=0x0000_1234, wdata=0xA5 → mm_wren high exactly one cycle (cycle 1) with mm_waddr=0x1234 and mm_wdata=0xA5; ack[0] in cycle 2; gnt[0] high cycles 1-2.
- Single read, RD_LAT=2: req[1]=1, we=0, addr=0x40; model returns 0x5C two cycles after raddr → ack[1] in cycle 4, rdata=0x5C, mm_wren never high.
- Contention, NREQ=2: req=2'b11 continuously, all reads → grants alternate 0,1,0,1; each ack goes only to the granted index; no two gnt bits high at once.
- Early drop: req[0] pulses for one cycle (write 0x77 to 0x10) → write still issued, ack[0] still pulses in cycle 2, no second write.
- Reset mid-read: assert rst during WAIT → gnt, busy and ack are 0 immediately, no ack ever; after release, req=2'b11 gives first grant to requester 0.
- Held req: req[0] held high through 3 writes with no other requester → ack[0] every 3 cycles, mm_wren pulses 3 times, busy drops for exactly one IDLE cycle between transactions.
